multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the MIPS-subset datapath. Sequences one instruction through
//  FETCH/DECODE/EXEC/MEM/WB and drives the select lines of the RegDst, ALUSrc and DatatoReg
//  muxes, the PC/IR/GRF write enables and the memory request handshake. It sits between the
//  IR fields and the datapath.
// PARAMETERS
//  TIMEOUT  16  max cycles a memory request may wait for mem_ack before a bus error
//  CNT_W    32  width of the retired-instruction counter
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  opcode     in   6      IR[31:26], stable after IRWrite
//  funct      in   6      IR[5:0]
//  zero       in   1      ALU zero flag, valid in EXEC
//  mem_ack    in   1      memory completes the current request this cycle
//  mem_req    out  1      memory request (fetch or data)
//  mem_we     out  1      request is a store (sw only)
//  PCWrite    out  1      load PC from NPC mux
//  NPCSel     out  2      00 PC+4, 01 branch target, 10 jal target, 11 GPR[rs]
//  IRWrite    out  1      latch instruction word
//  RegWrite   out  1      GRF write enable
//  RegDst     out  2      00 rt, 01 rd, 10 $31
//  ALUSrc     out  1      0 GPR[rt], 1 extended immediate
//  DatatoReg  out  2      00 ALU, 01 memory, 10 PC+4
//  ALUOp      out  3      000 add, 001 sub, 010 or, 011 lui (imm<<16)
//  ExtOp      out  1      0 zero-extend, 1 sign-extend
//  illegal    out  1      one-cycle pulse: unsupported instruction skipped
//  bus_err    out  1      sticky: memory timeout, FSM halted
//  retired    out  CNT_W  instructions completed since reset, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - States: INIT, FETCH, DECODE, EXEC, MEM, WB, HALT. While rst_n=0: state=INIT,
//    wait counter=0, retired=0, bus_err=0, all outputs 0. Reset mid-instruction aborts it; no
//    write enable may assert in the cycle rst_n falls.
//  - INIT -> FETCH unconditionally (one idle cycle after reset release; all outputs 0).
//  - FETCH: mem_req=1, mem_we=0. On mem_ack: IRWrite=1, PCWrite=1, NPCSel=00, go to DECODE.
//    Otherwise stay.
//  - DECODE: no enables. Next state by opcode/funct:
//    addu(000000/100001), subu(000000/100011), ori(001101), lui(001111), lw(100011),
//    sw(101011), beq(000100), jr(000000/001000) -> EXEC; jal(000011) -> WB.
//    Any other pair -> FETCH with illegal=1 for that cycle. nop (all zero) counts as illegal.
//  - EXEC: ALUOp/ALUSrc/ExtOp per instruction (addu/lw/sw add+sign; subu/beq sub;
//    ori or+zero; lui lui+ALUSrc=1). Next state: lw/sw -> MEM; addu/subu/ori/lui -> WB.
//    beq: PCWrite=zero, NPCSel=01 -> FETCH. jr: PCWrite=1, NPCSel=11 -> FETCH.
//  - MEM: mem_req=1, mem_we=(sw). On mem_ack: lw -> WB, sw -> FETCH.
//  - WB: RegWrite=1 for exactly one cycle, then -> FETCH.
//    R-type: RegDst=01, DatatoReg=00. ori/lui: 00/00. lw: 00/01.
//    jal: RegDst=10, DatatoReg=10, PCWrite=1, NPCSel=10.
//  - Hold ALUOp/ALUSrc/ExtOp from EXEC through MEM/WB. Outside EXEC/MEM/WB these selects and
//    all enables are 0.
//  - retired increments on every transition back to FETCH from EXEC, MEM or WB. It does not
//    increment on the illegal path.
//  - Wait counter: cleared on entering FETCH/MEM and on mem_ack. Incremented each cycle
//    mem_req=1 without mem_ack. Reaching TIMEOUT without ack: bus_err:=1, go to HALT.
//    An ack arriving in the TIMEOUT-th cycle wins.
//  - HALT: all outputs 0 except bus_err and retired; leave only via reset.
//  - mem_ack while mem_req=0 is ignored. mem_ack held high gives a single-cycle FETCH.
//  - CPI with immediate ack: R/ori/lui=4, lw=5, sw=4, beq/jr=3, jal=3.
// TESTING
//  - Reset then addu, ack immediate -> states INIT,F,D,E,W; WB: RegWrite=1,RegDst=01,DatatoReg=00; retired=1.
//  - lw with mem_ack delayed 3 cycles in MEM -> mem_req high 4 cycles, WB DatatoReg=01, total 8 cycles.
//  - beq with zero=1 then zero=0 -> PCWrite=1,NPCSel=01 only in the first case; no RegWrite either time.
//  - jal -> WB: RegDst=10, DatatoReg=10, PCWrite=1, NPCSel=10 in the same cycle; next state FETCH.
//  - Opcode 111111 -> illegal pulse 1 cycle in DECODE, retired unchanged; mem_ack never during FETCH -> bus_err=1 after 16 cycles, HALT.
//  - rst_n low during MEM of sw -> mem_we/mem_req drop asynchronously, retired=0, restart from INIT.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath.
// Walks one instruction through FETCH/DECODE/EXEC/MEM/WB, drives the datapath
// mux selects and write enables, and runs the memory request handshake.
//
// Handshake: mem_req is high for every cycle of a FETCH or MEM access. The
// access completes in the cycle where mem_req and mem_ack are both high. The
// FSM leaves the state on the next rising edge. mem_ack is ignored while
// mem_req is low.
//
// The state, decoded instruction class, wait counter, bus_err and retired are
// registered. The enables and selects are decoded from these registers in the
// same cycle. An ack therefore produces IRWrite/PCWrite in the cycle it
// arrives. An asynchronous reset also clears every output at once.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             PCWrite,
  output logic [1:0]       NPCSel,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic             ALUSrc,
  output logic [1:0]       DatatoReg,
  output logic [2:0]       ALUOp,
  output logic             ExtOp,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_JR, I_JAL, I_BAD
  } instr_t;

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] LAST_WAIT = WCW'(TIMEOUT - 1);

  state_t         state;
  instr_t         instr;
  instr_t         dec_instr;
  logic [WCW-1:0] wait_cnt;
  logic           timeout_hit;

  // Map an opcode/funct pair to an instruction class. Any pair outside the
  // supported subset, including the all-zero nop, is treated as illegal.
  function automatic instr_t decode(input logic [5:0] op, input logic [5:0] fn);
    instr_t d;
    d = I_BAD;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100001: d = I_ADDU;
          6'b100011: d = I_SUBU;
          6'b001000: d = I_JR;
          default:   d = I_BAD;
        endcase
      end
      6'b001101: d = I_ORI;
      6'b001111: d = I_LUI;
      6'b100011: d = I_LW;
      6'b101011: d = I_SW;
      6'b000100: d = I_BEQ;
      6'b000011: d = I_JAL;
      default:   d = I_BAD;
    endcase
    return d;
  endfunction

  assign dec_instr   = decode(opcode, funct);
  assign timeout_hit = (wait_cnt == LAST_WAIT);
  assign state_dbg   = state;

  // Sequence the instruction, time out memory waits, and count retirements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      instr    <= I_BAD;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
      retired  <= '0;
    end else begin
      case (state)
        S_INIT: begin
          state    <= S_FETCH;
          wait_cnt <= '0;
        end
        S_FETCH: begin
          if (mem_ack) begin
            state    <= S_DECODE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
            if (timeout_hit) begin
              bus_err <= 1'b1;
              state   <= S_HALT;
            end
          end
        end
        S_DECODE: begin
          instr <= dec_instr;
          case (dec_instr)
            I_BAD: begin
              state    <= S_FETCH;
              wait_cnt <= '0;
            end
            I_JAL:   state <= S_WB;
            default: state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (instr)
            I_LW, I_SW: begin
              state    <= S_MEM;
              wait_cnt <= '0;
            end
            I_BEQ, I_JR: begin
              state    <= S_FETCH;
              wait_cnt <= '0;
              retired  <= retired + CNT_W'(1);
            end
            default: state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            wait_cnt <= '0;
            if (instr == I_SW) begin
              state   <= S_FETCH;
              retired <= retired + CNT_W'(1);
            end else begin
              state <= S_WB;
            end
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
            if (timeout_hit) begin
              bus_err <= 1'b1;
              state   <= S_HALT;
            end
          end
        end
        S_WB: begin
          state    <= S_FETCH;
          wait_cnt <= '0;
          retired  <= retired + CNT_W'(1);
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

  // Decode enables and mux selects from the current state and instruction.
  // The ALU selects are set in EXEC and stay set through MEM and WB.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    PCWrite   = 1'b0;
    NPCSel    = 2'b00;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 2'b00;
    ALUSrc    = 1'b0;
    DatatoReg = 2'b00;
    ALUOp     = 3'b000;
    ExtOp     = 1'b0;
    illegal   = 1'b0;

    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      case (instr)
        I_ADDU: begin ALUOp = 3'b000; ALUSrc = 1'b0; ExtOp = 1'b1; end
        I_LW,
        I_SW:   begin ALUOp = 3'b000; ALUSrc = 1'b1; ExtOp = 1'b1; end
        I_SUBU,
        I_BEQ:  begin ALUOp = 3'b001; ALUSrc = 1'b0; ExtOp = 1'b0; end
        I_ORI:  begin ALUOp = 3'b010; ALUSrc = 1'b1; ExtOp = 1'b0; end
        I_LUI:  begin ALUOp = 3'b011; ALUSrc = 1'b1; ExtOp = 1'b0; end
        default: ;
      endcase
    end

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          NPCSel  = 2'b00;
        end
      end
      S_DECODE: illegal = (dec_instr == I_BAD);
      S_EXEC: begin
        if (instr == I_BEQ) begin
          PCWrite = zero;
          NPCSel  = 2'b01;
        end else if (instr == I_JR) begin
          PCWrite = 1'b1;
          NPCSel  = 2'b11;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (instr == I_SW);
      end
      S_WB: begin
        RegWrite = 1'b1;
        case (instr)
          I_ADDU, I_SUBU: RegDst = 2'b01;
          I_LW:           DatatoReg = 2'b01;
          I_JAL: begin
            RegDst    = 2'b10;
            DatatoReg = 2'b10;
            PCWrite   = 1'b1;
            NPCSel    = 2'b10;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. A transaction-level model predicts each
// visible control event: the cycle it happens in, the retired count at that
// point, and the control word. These predictions go into exp_q. A monitor
// pops and compares an entry whenever the DUT shows an enable, the illegal
// pulse, or a completed memory handshake.
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;
  localparam int EW      = 81;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4;
  localparam int K_SW = 5, K_BEQ = 6, K_JR = 7, K_JAL = 8, K_BAD = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       opcode = '0;
  logic [5:0]       funct = '0;
  logic             zero = 1'b0;
  logic             mem_ack = 1'b0;
  logic             mem_req, mem_we, PCWrite, IRWrite, RegWrite, ALUSrc, ExtOp;
  logic             illegal, bus_err;
  logic [1:0]       NPCSel, RegDst, DatatoReg;
  logic [2:0]       ALUOp, state_dbg;
  logic [CNT_W-1:0] retired;

  logic [EW-1:0]    exp_q[$];
  int               checks = 0;
  int               failures = 0;
  int unsigned      next_t;
  int unsigned      done_cnt;
  int unsigned      cyc;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .PCWrite(PCWrite),
    .NPCSel(NPCSel), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrc(ALUSrc), .DatatoReg(DatatoReg), .ALUOp(ALUOp), .ExtOp(ExtOp),
    .illegal(illegal), .bus_err(bus_err), .retired(retired), .state_dbg(state_dbg)
  );

  // Clock and reset-relative cycle counter. The first FETCH cycle is cycle 1.
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Pack the control word in a fixed field order.
  function automatic logic [16:0] ctl(
    input logic mr, input logic mw, input logic pcw, input logic [1:0] npc,
    input logic irw, input logic rw, input logic [1:0] rd, input logic as,
    input logic [1:0] d2r, input logic [2:0] aop, input logic ext, input logic ill);
    return {mr, mw, pcw, npc, irw, rw, rd, as, d2r, aop, ext, ill};
  endfunction

  function automatic logic [16:0] dut_ctl();
    return ctl(mem_req, mem_we, PCWrite, NPCSel, IRWrite, RegWrite, RegDst,
               ALUSrc, DatatoReg, ALUOp, ExtOp, illegal);
  endfunction

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) return (fn == 6'b100001 || fn == 6'b100011 || fn == 6'b001000);
    return (op == 6'b001101 || op == 6'b001111 || op == 6'b100011 ||
            op == 6'b101011 || op == 6'b000100 || op == 6'b000011);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_ev(input int unsigned t, input logic [16:0] c);
    exp_q.push_back({32'(t), 32'(done_cnt), c});
  endtask

  // Reference model. Event times follow the per-class CPI rules:
  // fetch ack at t+fd, DECODE at +1, EXEC/jal-WB at +2, WB or MEM start at +3.
  task automatic model(input int kind, input logic z, input int fd, input int md, input bit cut);
    int unsigned f;
    f = next_t + fd;
    push_ev(f, ctl(1, 0, 1, 2'b00, 1, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0));
    if (cut) return;
    case (kind)
      K_BAD: begin
        push_ev(f + 1, ctl(0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1));
        next_t = f + 2;
      end
      K_BEQ: begin
        if (z) push_ev(f + 2, ctl(0, 0, 1, 2'b01, 0, 0, 2'b00, 0, 2'b00, 3'b001, 0, 0));
        next_t = f + 3;
        done_cnt++;
      end
      K_JR: begin
        push_ev(f + 2, ctl(0, 0, 1, 2'b11, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0));
        next_t = f + 3;
        done_cnt++;
      end
      K_JAL: begin
        push_ev(f + 2, ctl(0, 0, 1, 2'b10, 0, 1, 2'b10, 0, 2'b10, 3'b000, 0, 0));
        next_t = f + 3;
        done_cnt++;
      end
      K_LW: begin
        push_ev(f + 3 + md, ctl(1, 0, 0, 2'b00, 0, 0, 2'b00, 1, 2'b00, 3'b000, 1, 0));
        push_ev(f + 4 + md, ctl(0, 0, 0, 2'b00, 0, 1, 2'b00, 1, 2'b01, 3'b000, 1, 0));
        next_t = f + 5 + md;
        done_cnt++;
      end
      K_SW: begin
        push_ev(f + 3 + md, ctl(1, 1, 0, 2'b00, 0, 0, 2'b00, 1, 2'b00, 3'b000, 1, 0));
        next_t = f + 4 + md;
        done_cnt++;
      end
      K_ADDU: begin
        push_ev(f + 3, ctl(0, 0, 0, 2'b00, 0, 1, 2'b01, 0, 2'b00, 3'b000, 1, 0));
        next_t = f + 4;
        done_cnt++;
      end
      K_SUBU: begin
        push_ev(f + 3, ctl(0, 0, 0, 2'b00, 0, 1, 2'b01, 0, 2'b00, 3'b001, 0, 0));
        next_t = f + 4;
        done_cnt++;
      end
      K_ORI: begin
        push_ev(f + 3, ctl(0, 0, 0, 2'b00, 0, 1, 2'b00, 1, 2'b00, 3'b010, 0, 0));
        next_t = f + 4;
        done_cnt++;
      end
      default: begin
        push_ev(f + 3, ctl(0, 0, 0, 2'b00, 0, 1, 2'b00, 1, 2'b00, 3'b011, 0, 0));
        next_t = f + 4;
        done_cnt++;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for mem_req, throwing random acks at the DUT while mem_req is low.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (mem_req) begin
        ok = 1'b1;
        return;
      end
      mem_ack = 1'($urandom_range(0, 1));
      tick();
    end
    checks++;
    failures++;
    $display("FAIL wait_mem_req: mem_req stayed 0 for 64 cycles, expected 1");
  endtask

  task automatic pick(input int kind, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    case (kind)
      K_ADDU: begin op = 6'b000000; fn = 6'b100001; end
      K_SUBU: begin op = 6'b000000; fn = 6'b100011; end
      K_JR:   begin op = 6'b000000; fn = 6'b001000; end
      K_ORI:  op = 6'b001101;
      K_LUI:  op = 6'b001111;
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_BEQ:  op = 6'b000100;
      K_JAL:  op = 6'b000011;
      default: begin
        do begin
          op = 6'($urandom);
          fn = 6'($urandom);
          if ($urandom_range(0, 1) == 1) op = 6'b000000;
        end while (legal(op, fn));
      end
    endcase
  endtask

  // Drive one instruction: fetch ack after fd wait cycles, then a data ack after md cycles.
  task automatic run_instr(input int kind, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fd, input int md, input bit cut);
    bit ok;
    model(kind, z, fd, md, cut);
    wait_req(ok);
    if (!ok) return;
    opcode = op;
    funct = fn;
    zero = z;
    mem_ack = 1'b0;
    repeat (fd) tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    if (kind == K_LW || kind == K_SW) begin
      wait_req(ok);
      if (!ok) return;
      mem_ack = 1'b0;
      if (cut) return;
      repeat (md) tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
  endtask

  task automatic run_kind(input int kind, input logic z, input int fd, input int md);
    logic [5:0] op, fn;
    pick(kind, op, fn);
    run_instr(kind, op, fn, z, fd, md, 1'b0);
  endtask

  // Drain the expected queue and stop in the first cycle of the next FETCH.
  task automatic settle(input string name);
    mem_ack = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && mem_req) begin
        chk(name, 64'(retired), 64'(done_cnt));
        return;
      end
      tick();
    end
    checks++;
    failures++;
    $display("FAIL %s_settle: %0d events still pending after 200 cycles, expected 0", name, exp_q.size());
  endtask

  // Monitor: compare every visible control event with the head of exp_q.
  initial begin : monitor
    logic [EW-1:0] got, e;
    forever begin
      @(negedge clk);
      if (rst_n && (IRWrite || PCWrite || RegWrite || illegal || (mem_req && mem_ack))) begin
        got = {32'(cyc), 32'(retired), dut_ctl()};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL event: unexpected event cyc=%0d retired=%0d ctrl=%h, expected none",
                   got[80:49], got[48:17], got[16:0]);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL event: got cyc=%0d retired=%0d ctrl=%h expected cyc=%0d retired=%0d ctrl=%h",
                     got[80:49], got[48:17], got[16:0], e[80:49], e[48:17], e[16:0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    failures++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int n, kind, fd, md;
    logic [5:0] op6;

    // Reset: all outputs cleared while rst_n is low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 64'(dut_ctl()), 64'(0));
    chk("reset_state", 64'(state_dbg), 64'(0));
    chk("reset_retired", 64'(retired), 64'(0));
    chk("reset_bus_err", 64'(bus_err), 64'(0));
    tick();
    rst_n = 1'b1;
    next_t = 1;
    done_cnt = 0;
    @(negedge clk);
    chk("init_idle_state", 64'(state_dbg), 64'(0));
    chk("init_idle_ctrl", 64'(dut_ctl()), 64'(0));
    tick();

    // Directed cases.
    run_kind(K_ADDU, 1'b0, 0, 0);
    settle("retired_after_addu");
    chk("retired_is_one", 64'(retired), 64'(1));
    run_kind(K_LW, 1'b0, 0, 3);
    run_kind(K_BEQ, 1'b1, 0, 0);
    run_kind(K_BEQ, 1'b0, 0, 0);
    run_kind(K_JAL, 1'b0, 0, 0);
    op6 = 6'b111111;
    run_instr(K_BAD, op6, 6'b000000, 1'b0, 0, 0, 1'b0);
    op6 = 6'b000000;
    run_instr(K_BAD, op6, 6'b000000, 1'b0, 1, 0, 1'b0);
    run_kind(K_SW, 1'b0, TIMEOUT - 1, TIMEOUT - 1);
    run_kind(K_JR, 1'b0, 2, 0);
    run_kind(K_SUBU, 1'b0, 0, 0);
    run_kind(K_ORI, 1'b0, 1, 0);
    run_kind(K_LUI, 1'b0, 0, 0);
    settle("retired_after_directed");

    // Randomized instruction stream.
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      fd = ($urandom_range(0, 7) == 0) ? (TIMEOUT - 1) : $urandom_range(0, 3);
      md = ($urandom_range(0, 7) == 0) ? (TIMEOUT - 1) : $urandom_range(0, 3);
      run_kind(kind, 1'($urandom_range(0, 1)), fd, md);
    end
    settle("retired_after_random");

    // Fetch never acknowledged: 16 request cycles, then bus_err and HALT.
    n = 0;
    repeat (TIMEOUT) begin
      @(negedge clk);
      if (mem_req && !bus_err) n++;
    end
    chk("timeout_req_cycles", 64'(n), 64'(TIMEOUT));
    @(negedge clk);
    chk("bus_err_set", 64'(bus_err), 64'(1));
    chk("halt_state", 64'(state_dbg), 64'(6));
    chk("halt_ctrl", 64'(dut_ctl()), 64'(0));
    mem_ack = 1'b1;
    repeat (5) tick();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("halt_sticky_state", 64'(state_dbg), 64'(6));
    chk("halt_sticky_bus_err", 64'(bus_err), 64'(1));
    chk("halt_retired", 64'(retired), 64'(done_cnt));

    // Reset out of HALT, then reset in the middle of a store's MEM wait.
    tick();
    rst_n = 1'b0;
    tick();
    chk("reset_clears_bus_err", 64'(bus_err), 64'(0));
    rst_n = 1'b1;
    next_t = 1;
    done_cnt = 0;
    run_instr(K_SW, 6'b101011, 6'b000000, 1'b0, 1, 0, 1'b1);
    tick();
    chk("sw_mem_we_before_reset", 64'({mem_req, mem_we}), 64'(2'b11));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", 64'(dut_ctl()), 64'(0));
    chk("async_reset_retired", 64'(retired), 64'(0));
    chk("async_reset_state", 64'(state_dbg), 64'(0));
    tick();
    rst_n = 1'b1;
    next_t = 1;
    done_cnt = 0;
    run_kind(K_ADDU, 1'b0, 0, 0);
    settle("retired_after_restart");
    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
